// File: rtl/pulpemu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pulpemu_pkg
//  Description : Shared types and constants for the PULP emulation reset
//                sequencer: FSM state encoding and shared counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package pulpemu_pkg;

    // Width of the shared sequencing counter (holds loads up to 65535).
    localparam int RST_SEQ_CNT_W = 17;

    // Sequencer states; encodings are visible on state_o for debug probes.
    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        LOCK_FILT = 3'd1,
        HOLD      = 3'd2,
        SOC_UP    = 3'd3,
        RUN       = 3'd4,
        BTN       = 3'd5
    } rst_seq_state_e;

endpackage : pulpemu_pkg
`default_nettype wire

// File: rtl/pulpemu_sync.sv
`default_nettype none
// ============================================================================
//  Module      : pulpemu_sync
//  Description : Two-flop synchronizer for a single-bit asynchronous input,
//                with asynchronous active-low reset to RESET_VALUE.
//  Ports       : clk   - destination clock
//                rst_n - asynchronous active-low reset
//                d     - asynchronous input
//                q     - synchronized output
//  Revision    : 1.0 - initial release
// ============================================================================
module pulpemu_sync #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RESET_VALUE;
            r_sync <= RESET_VALUE;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule : pulpemu_sync
`default_nettype wire

// File: rtl/pulpemu_rst_seq.sv
`default_nettype none
// ============================================================================
//  Module      : pulpemu_rst_seq
//  Description : FPGA-emulation reset sequencer. Synchronizes the clock
//                manager lock and the board reset button, qualifies lock
//                stability, then releases SoC reset followed by cluster
//                reset after fixed counted delays. Lock loss or a button
//                press re-asserts both resets and restarts the sequence.
//  Config      : PULPEMU_RST_DEBOUNCE_EN - when defined, the synchronized
//                button is debounced over DEBOUNCE_CYCLES stable cycles.
//  Ports       : clk_i          - sequencer clock
//                rstn_i         - asynchronous active-low reset
//                locked_i       - clock-manager lock (asynchronous)
//                btn_rst_i      - board reset button, active-high (async)
//                soc_rstn_o     - SoC reset, active-low, registered
//                cluster_rstn_o - cluster reset, active-low, registered
//                ready_o        - high only in RUN
//                lock_lost_o    - sticky: lock dropped after SoC release
//                state_o        - current FSM state encoding
//  Revision    : 1.0 - initial release
// ============================================================================
module pulpemu_rst_seq
    import pulpemu_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES   = 256,
    parameter int HOLD_CYCLES          = 64,
    parameter int CLUSTER_DELAY_CYCLES = 16,
    parameter int DEBOUNCE_CYCLES      = 1024
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       locked_i,
    input  logic       btn_rst_i,
    output logic       soc_rstn_o,
    output logic       cluster_rstn_o,
    output logic       ready_o,
    output logic       lock_lost_o,
    output logic [2:0] state_o
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter range checks
    // ------------------------------------------------------------------
    if (LOCK_STABLE_CYCLES < 1 || LOCK_STABLE_CYCLES > 65536) begin : g_chk_lock
        $error("LOCK_STABLE_CYCLES out of range 1..65536");
    end
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 65536) begin : g_chk_hold
        $error("HOLD_CYCLES out of range 1..65536");
    end
    if (CLUSTER_DELAY_CYCLES < 1 || CLUSTER_DELAY_CYCLES > 65536) begin : g_chk_cluster
        $error("CLUSTER_DELAY_CYCLES out of range 1..65536");
    end
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65536) begin : g_chk_debounce
        $error("DEBOUNCE_CYCLES out of range 1..65536");
    end

    // Counter loads: the count runs N-1 down to 0, so a state lasts N cycles.
    localparam logic [RST_SEQ_CNT_W-1:0] c_LOCK_LOAD    = RST_SEQ_CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RST_SEQ_CNT_W-1:0] c_HOLD_LOAD    = RST_SEQ_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [RST_SEQ_CNT_W-1:0] c_CLUSTER_LOAD = RST_SEQ_CNT_W'(CLUSTER_DELAY_CYCLES - 1);
    localparam logic [RST_SEQ_CNT_W-1:0] c_CNT_ZERO     = '0;
    localparam logic [RST_SEQ_CNT_W-1:0] c_CNT_ONE      = RST_SEQ_CNT_W'(1);

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    logic w_lock_s;
    logic w_btn_s;
    logic w_btn_p;

    pulpemu_sync #(
        .RESET_VALUE (1'b0)
    ) u_sync_lock (
        .clk   (clk_i),
        .rst_n (rstn_i),
        .d     (locked_i),
        .q     (w_lock_s)
    );

    pulpemu_sync #(
        .RESET_VALUE (1'b0)
    ) u_sync_btn (
        .clk   (clk_i),
        .rst_n (rstn_i),
        .d     (btn_rst_i),
        .q     (w_btn_s)
    );

    // ------------------------------------------------------------------
    // Button qualification
    // ------------------------------------------------------------------
`ifdef PULPEMU_RST_DEBOUNCE_EN
    localparam logic [RST_SEQ_CNT_W-1:0] c_DB_LOAD = RST_SEQ_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                     r_btn_p;
    logic [RST_SEQ_CNT_W-1:0] r_db_cnt;

    // The pressed level follows the synchronized button only once the new
    // level has persisted for DEBOUNCE_CYCLES; any return to the current
    // level re-arms the count.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_btn_p  <= 1'b0;
            r_db_cnt <= c_DB_LOAD;
        end else if (w_btn_s == r_btn_p) begin
            r_db_cnt <= c_DB_LOAD;
        end else if (r_db_cnt == c_CNT_ZERO) begin
            r_btn_p  <= w_btn_s;
            r_db_cnt <= c_DB_LOAD;
        end else begin
            r_db_cnt <= r_db_cnt - c_CNT_ONE;
        end
    end

    assign w_btn_p = r_btn_p;
`else
    assign w_btn_p = w_btn_s;
`endif

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    rst_seq_state_e           r_state;
    rst_seq_state_e           w_state_nxt;
    logic [RST_SEQ_CNT_W-1:0] r_cnt;
    logic [RST_SEQ_CNT_W-1:0] w_cnt_nxt;
    logic                     w_lock_lost_set;
    logic                     r_lock_lost;
    logic                     r_soc_rstn;
    logic                     r_cluster_rstn;
    logic                     w_soc_rstn_nxt;
    logic                     w_cluster_rstn_nxt;

    // Process 1: state, counter and registered outputs.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state        <= WAIT_LOCK;
            r_cnt          <= c_CNT_ZERO;
            r_lock_lost    <= 1'b0;
            r_soc_rstn     <= 1'b0;
            r_cluster_rstn <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_lock_lost    <= r_lock_lost | w_lock_lost_set;
            r_soc_rstn     <= w_soc_rstn_nxt;
            r_cluster_rstn <= w_cluster_rstn_nxt;
        end
    end

    // Process 2: next state and counter. The counter free-runs down to
    // zero and is reloaded on every transition.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = (r_cnt != c_CNT_ZERO) ? (r_cnt - c_CNT_ONE) : r_cnt;
        w_lock_lost_set = 1'b0;

        // Button wins over a simultaneous lock drop.
        if (r_state != BTN && w_btn_p) begin
            w_state_nxt = BTN;
            w_cnt_nxt   = c_CNT_ZERO;
        end else begin
            case (r_state)
                WAIT_LOCK: begin
                    if (w_lock_s) begin
                        w_state_nxt = LOCK_FILT;
                        w_cnt_nxt   = c_LOCK_LOAD;
                    end
                end
                LOCK_FILT: begin
                    if (!w_lock_s) begin
                        w_state_nxt = WAIT_LOCK;
                        w_cnt_nxt   = c_CNT_ZERO;
                    end else if (r_cnt == c_CNT_ZERO) begin
                        w_state_nxt = HOLD;
                        w_cnt_nxt   = c_HOLD_LOAD;
                    end
                end
                HOLD: begin
                    if (!w_lock_s) begin
                        w_state_nxt = WAIT_LOCK;
                        w_cnt_nxt   = c_CNT_ZERO;
                    end else if (r_cnt == c_CNT_ZERO) begin
                        w_state_nxt = SOC_UP;
                        w_cnt_nxt   = c_CLUSTER_LOAD;
                    end
                end
                SOC_UP: begin
                    // SoC is already out of reset: record the loss.
                    if (!w_lock_s) begin
                        w_state_nxt     = WAIT_LOCK;
                        w_cnt_nxt       = c_CNT_ZERO;
                        w_lock_lost_set = 1'b1;
                    end else if (r_cnt == c_CNT_ZERO) begin
                        w_state_nxt = RUN;
                        w_cnt_nxt   = c_CNT_ZERO;
                    end
                end
                RUN: begin
                    if (!w_lock_s) begin
                        w_state_nxt     = WAIT_LOCK;
                        w_cnt_nxt       = c_CNT_ZERO;
                        w_lock_lost_set = 1'b1;
                    end
                end
                BTN: begin
                    // Lock is ignored while the button holds the chip in reset.
                    if (!w_btn_p) begin
                        w_state_nxt = WAIT_LOCK;
                        w_cnt_nxt   = c_CNT_ZERO;
                    end
                end
                default: begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = c_CNT_ZERO;
                end
            endcase
        end
    end

    // Process 3: output decode from the next state, so the registered
    // resets change on the same edge as the state register.
    always_comb begin
        w_soc_rstn_nxt     = 1'b0;
        w_cluster_rstn_nxt = 1'b0;
        if (w_state_nxt == SOC_UP || w_state_nxt == RUN) begin
            w_soc_rstn_nxt = 1'b1;
        end
        if (w_state_nxt == RUN) begin
            w_cluster_rstn_nxt = 1'b1;
        end
    end

    assign soc_rstn_o     = r_soc_rstn;
    assign cluster_rstn_o = r_cluster_rstn;
    assign ready_o        = r_cluster_rstn;
    assign lock_lost_o    = r_lock_lost;
    assign state_o        = r_state;

endmodule : pulpemu_rst_seq
`default_nettype wire
